bitstream_loader: RTL

- Upstream configuration stage of the MeshOfTree fabric.
- Accepts the bitstream as a byte stream on a valid/ready interface and assembles each record into an address word and a data word.
- Presents each record on the fabric's address/data configuration port, then strobes conf a programmed number of times.
- Asserts done once NUM_WORDS records are written, so the fabric can leave configuration mode and start running.

---
 rtl/bitstream_loader_if.sv | 23 ++
 rtl/bitstream_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bitstream_loader_if.sv
// Byte-stream input and fabric configuration port of the bitstream loader.
// slave is the loader's view; master is the upstream source / fabric side.
interface bitstream_loader_if #(
  parameter int ADDRESS_SIZE = 15,
  parameter int DATA_SIZE    = 8
);
  logic [7:0]              in_byte;
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDRESS_SIZE-1:0] address;
  logic [DATA_SIZE-1:0]    data;
  logic                    conf;

  modport master (
    output in_byte, in_valid,
    input  in_ready, address, data, conf
  );

  modport slave (
    input  in_byte, in_valid,
    output in_ready, address, data, conf
  );
endinterface

// File: rtl/bitstream_loader.sv
// Assembles byte-stream records into address/data words and strobes them
// into the MeshOfTree fabric configuration port, CONF_PULSES times each.
module bitstream_loader #(
  parameter int ADDRESS_SIZE = 15,
  parameter int DATA_SIZE    = 8,
  parameter int NUM_WORDS    = 34878,
  parameter int CONF_PULSES  = 4,
  parameter int CONF_HIGH    = 1,
  parameter int CONF_LOW     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  bitstream_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [15:0]       word_count
);

  localparam int unsigned AB   = (ADDRESS_SIZE + 7) / 8;
  localparam int unsigned DB   = (DATA_SIZE + 7) / 8;
  localparam int unsigned BMAX = (AB > DB) ? AB : DB;
  localparam int unsigned TMAX = (CONF_HIGH > CONF_LOW) ? CONF_HIGH : CONF_LOW;
  localparam int unsigned BC_W = $clog2(BMAX) + 1;
  localparam int unsigned TC_W = $clog2(TMAX) + 1;
  localparam int unsigned PC_W = $clog2(CONF_PULSES) + 1;

  localparam logic [BC_W-1:0] A_LAST = BC_W'(AB - 1);
  localparam logic [BC_W-1:0] D_LAST = BC_W'(DB - 1);
  localparam logic [TC_W-1:0] H_LAST = TC_W'(CONF_HIGH - 1);
  localparam logic [TC_W-1:0] L_LAST = TC_W'(CONF_LOW - 1);
  localparam logic [PC_W-1:0] P_LAST = PC_W'(CONF_PULSES - 1);
  localparam logic [15:0]     NW     = 16'(NUM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [BC_W-1:0]         byte_cnt_q, byte_cnt_d;
  logic [TC_W-1:0]         tcnt_q, tcnt_d;
  logic [PC_W-1:0]         pcnt_q, pcnt_d;
  logic [ADDRESS_SIZE-1:0] addr_sr_q, addr_sr_d;
  logic [DATA_SIZE-1:0]    data_sr_q, data_sr_d;
  logic [ADDRESS_SIZE-1:0] address_q, address_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;
  logic [15:0]             word_count_q, word_count_d;
  logic                    in_ready_q;
  logic                    conf_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    xfer;

  assign xfer = bus.in_valid & in_ready_q;

  // Shift registers are exactly field-wide, so high bits of the top byte fall off.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    tcnt_d       = tcnt_q;
    pcnt_d       = pcnt_q;
    addr_sr_d    = addr_sr_q;
    data_sr_d    = data_sr_q;
    address_d    = address_q;
    data_d       = data_q;
    word_count_d = word_count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_ADDR;
          byte_cnt_d   = '0;
          word_count_d = '0;
        end
      end

      S_ADDR: begin
        if (xfer) begin
          addr_sr_d = ADDRESS_SIZE'({addr_sr_q, bus.in_byte});
          if (byte_cnt_q == A_LAST) begin
            byte_cnt_d = '0;
            state_d    = S_DATA;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          data_sr_d = DATA_SIZE'({data_sr_q, bus.in_byte});
          if (byte_cnt_q == D_LAST) begin
            byte_cnt_d = '0;
            address_d  = addr_sr_q;
            data_d     = data_sr_d;
            state_d    = S_SETUP;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S_SETUP: begin
        tcnt_d  = '0;
        pcnt_d  = '0;
        state_d = S_HIGH;
      end

      S_HIGH: begin
        if (tcnt_q == H_LAST) begin
          tcnt_d  = '0;
          state_d = S_LOW;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      S_LOW: begin
        if (tcnt_q == L_LAST) begin
          tcnt_d = '0;
          if (pcnt_q == P_LAST) begin
            pcnt_d = '0;
            if (word_count_q != NW) begin
              word_count_d = word_count_q + 16'd1;
            end
            state_d = (word_count_d == NW) ? S_DONE : S_ADDR;
          end else begin
            pcnt_d  = pcnt_q + 1'b1;
            state_d = S_HIGH;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      tcnt_q       <= '0;
      pcnt_q       <= '0;
      addr_sr_q    <= '0;
      data_sr_q    <= '0;
      address_q    <= '0;
      data_q       <= '0;
      word_count_q <= '0;
      in_ready_q   <= 1'b0;
      conf_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      tcnt_q       <= tcnt_d;
      pcnt_q       <= pcnt_d;
      addr_sr_q    <= addr_sr_d;
      data_sr_q    <= data_sr_d;
      address_q    <= address_d;
      data_q       <= data_d;
      word_count_q <= word_count_d;
      in_ready_q   <= (state_d == S_ADDR) || (state_d == S_DATA);
      conf_q       <= (state_d == S_HIGH);
      busy_q       <= !((state_d == S_IDLE) || (state_d == S_DONE));
      done_q       <= (state_d == S_DONE);
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.address  = address_q;
  assign bus.data     = data_q;
  assign bus.conf     = conf_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign word_count   = word_count_q;

endmodule
